// File: rtl/fft_seq_if.sv
// Handshake/bus bundle between the FFT stage sequencer and its control/datapath peers.
// Optional IFFT ports exist only when FFT_SEQ_INVERSE_EN is defined.
interface fft_seq_if #(
   parameter int SW = 3,
   parameter int PW = 1
);
   logic          start;
   logic          busy;
   logic          done;
   logic          bf_valid;
   logic          bf_ready;
   logic [SW-1:0] stage_idx;
   logic [PW-1:0] pass_idx;
   logic          buf_sel;
   logic          wb_ack;
   logic          err;
`ifdef FFT_SEQ_INVERSE_EN
   logic          inverse;
   logic          coeff_conj;

   modport master (
      input  start, bf_ready, wb_ack, inverse,
      output busy, done, bf_valid, stage_idx, pass_idx, buf_sel, err, coeff_conj
   );
   modport slave (
      output start, bf_ready, wb_ack, inverse,
      input  busy, done, bf_valid, stage_idx, pass_idx, buf_sel, err, coeff_conj
   );
`else
   modport master (
      input  start, bf_ready, wb_ack,
      output busy, done, bf_valid, stage_idx, pass_idx, buf_sel, err
   );
   modport slave (
      output start, bf_ready, wb_ack,
      input  busy, done, bf_valid, stage_idx, pass_idx, buf_sel, err
   );
`endif
endinterface

// File: rtl/fft_stage_sequencer.sv
// Walks the butterfly datapath through LOG2N stages of PASSES beats each, with a per-stage
// write-back barrier and ping-pong bank swap. FFT_SEQ_INVERSE_EN adds inverse/coeff_conj.
module fft_stage_sequencer #(
   parameter int N_FFT = 128,
   parameter int LANES = 32,
   parameter int LOG2N = 7,
   parameter int SW    = 3,
   parameter int PW    = 1
) (
   input logic       clk,
   input logic       rst_n,
   fft_seq_if.master bus
);
   localparam int PASSES = N_FFT / (2 * LANES);
   localparam int OW     = $clog2(PASSES + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

   state_t        state, state_nxt;
   logic [OW-1:0] outstanding;
   logic [SW-1:0] stage_q;
   logic [PW-1:0] pass_q;
   logic          buf_q;
   logic          err_q;
   logic          accept, ack_ok, last_pass, last_stage, drained;

   assign accept     = (state == ISSUE) && bus.bf_ready;
   assign ack_ok     = bus.wb_ack && (outstanding != '0);
   assign last_pass  = (pass_q == PW'(PASSES - 1));
   assign last_stage = (stage_q == SW'(LOG2N - 1));
   assign drained    = (state == DRAIN) && (outstanding == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start)             state_nxt = ISSUE;
         ISSUE:   if (accept && last_pass)   state_nxt = DRAIN;
         DRAIN:   if (drained)               state_nxt = last_stage ? FINISH : ISSUE;
         FINISH:                             state_nxt = IDLE;
         default:                            state_nxt = IDLE;
      endcase
   end

   // The bank swaps after every stage, including the last, so buf_sel ends on the result bank.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding <= '0;
         stage_q     <= '0;
         pass_q      <= '0;
         buf_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         case ({accept, ack_ok})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
         if (bus.wb_ack && (outstanding == '0)) err_q <= 1'b1;
         if ((state == IDLE) && bus.start) begin
            stage_q <= '0;
            pass_q  <= '0;
            buf_q   <= 1'b0;
         end
         if (accept && !last_pass) pass_q <= pass_q + 1'b1;
         if (drained) begin
            buf_q <= ~buf_q;
            if (!last_stage) begin
               stage_q <= stage_q + 1'b1;
               pass_q  <= '0;
            end
         end
      end
   end

`ifdef FFT_SEQ_INVERSE_EN
   logic conj_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          conj_q <= 1'b0;
      else if ((state == IDLE) && bus.start) conj_q <= bus.inverse;
   end

   assign bus.coeff_conj = conj_q;
`endif

   assign bus.busy      = (state == ISSUE) || (state == DRAIN);
   assign bus.done      = (state == FINISH);
   assign bus.bf_valid  = (state == ISSUE);
   assign bus.stage_idx = stage_q;
   assign bus.pass_idx  = pass_q;
   assign bus.buf_sel   = buf_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Randomized self-checking bench for fft_stage_sequencer against a beat/ack/barrier model.
// Build with FFT_SEQ_INVERSE_EN defined to also exercise coeff_conj.
module tb_fft_stage_sequencer;
   localparam int N_FFT  = 128;
   localparam int LANES  = 32;
   localparam int LOG2N  = 7;
   localparam int SW     = 3;
   localparam int PW     = 1;
   localparam int PASSES = N_FFT / (2 * LANES);
   localparam int TOTAL  = LOG2N * PASSES;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fft_seq_if #(.SW(SW), .PW(PW)) bus ();

   fft_stage_sequencer #(
      .N_FFT(N_FFT), .LANES(LANES), .LOG2N(LOG2N), .SW(SW), .PW(PW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // run configuration, written only by the main process
   int cfg_dly  = 3;
   int cfg_dly0 = 3;
   int cfg_hold = 0;
   bit cfg_rnd  = 1'b0;
   int spur_req = 0;

   // ready/ack driver: one ack per accepted beat, after a configured delay, in order
   int dcyc = 0;
   int acks_sent = 0;
   int spur_done = 0;
   int hold_cnt = 0;
   int last_due = 0;
   int ackq[$];
   bit pend = 1'b0;
   int pend_stage = 0;

   always @(posedge clk) begin
      int  d, due;
      bit  ack, rdy;
      #1;
      dcyc++;
      if (!rst_n) begin
         ackq.delete();
         pend        = 1'b0;
         hold_cnt    = 0;
         last_due    = 0;
         bus.wb_ack  = 1'b0;
         bus.bf_ready = 1'b0;
      end else begin
         if (pend) begin
            d = (pend_stage == 0) ? cfg_dly0 : cfg_dly;
            if (cfg_rnd) d = int'($urandom_range(1, 6));
            due = dcyc + d;
            if (due <= last_due) due = last_due + 1;
            ackq.push_back(due);
            last_due = due;
         end
         ack = 1'b0;
         if (ackq.size() > 0 && ackq[0] <= dcyc) begin
            void'(ackq.pop_front());
            ack = 1'b1;
            acks_sent++;
         end else if (spur_req != spur_done) begin
            spur_done++;
            ack = 1'b1;
         end
         bus.wb_ack = ack;
         if (!bus.busy) hold_cnt = 0;
         rdy = cfg_rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (bus.bf_valid && bus.stage_idx == 2 && bus.pass_idx == 1 && hold_cnt < cfg_hold) begin
            rdy = 1'b0;
            hold_cnt++;
         end
         bus.bf_ready = rdy;
         pend         = bus.bf_valid && rdy;
         pend_stage   = int'(bus.stage_idx);
      end
   end

   // monitor: expected beat order is simply beat n -> (n / PASSES, n % PASSES)
   int run_beat = 0;
   int ack_base = 0;
   int done_cnt = 0;
   int last_stage = -1;
   bit prev_stall = 1'b0;
   int prev_s = 0, prev_p = 0;
   bit exp_conj = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
         last_stage = -1;
         run_beat   = 0;
      end else begin
         if (bus.start && !bus.busy && !bus.done) begin
            run_beat   = 0;
            ack_base   = acks_sent;
            last_stage = -1;
`ifdef FFT_SEQ_INVERSE_EN
            exp_conj   = bus.inverse;
`endif
         end
         if (prev_stall) begin
            check("hold_valid", 32'(bus.bf_valid), 32'd1);
            check("hold_stage", 32'(bus.stage_idx), 32'(prev_s));
            check("hold_pass",  32'(bus.pass_idx),  32'(prev_p));
         end
         if (bus.bf_valid && int'(bus.stage_idx) != last_stage) begin
            check("barrier", 32'(acks_sent - ack_base), 32'(int'(bus.stage_idx) * PASSES));
            last_stage = int'(bus.stage_idx);
         end
         if (bus.bf_valid && bus.bf_ready) begin
            check("beat_in_range", 32'(run_beat < TOTAL), 32'd1);
            check("beat_stage", 32'(bus.stage_idx), 32'(run_beat / PASSES));
            check("beat_pass",  32'(bus.pass_idx),  32'(run_beat % PASSES));
            run_beat++;
         end
         prev_stall = bus.bf_valid && !bus.bf_ready;
         prev_s     = int'(bus.stage_idx);
         prev_p     = int'(bus.pass_idx);
         if (bus.done) begin
            done_cnt++;
            check("beats_total", 32'(run_beat), 32'(TOTAL));
            check("done_busy", 32'(bus.busy), 32'd0);
            check("done_bufsel", 32'(bus.buf_sel), 32'(LOG2N % 2));
         end
`ifdef FFT_SEQ_INVERSE_EN
         if (bus.busy) check("coeff_conj", 32'(bus.coeff_conj), 32'(exp_conj));
`endif
      end
   end

   bit exp_err = 1'b0;

   task automatic check_zero_outputs(input string tag);
      check({tag, "_busy"},  32'(bus.busy),      32'd0);
      check({tag, "_done"},  32'(bus.done),      32'd0);
      check({tag, "_valid"}, 32'(bus.bf_valid),  32'd0);
      check({tag, "_stage"}, 32'(bus.stage_idx), 32'd0);
      check({tag, "_pass"},  32'(bus.pass_idx),  32'd0);
      check({tag, "_buf"},   32'(bus.buf_sel),   32'd0);
      check({tag, "_err"},   32'(bus.err),       32'd0);
`ifdef FFT_SEQ_INVERSE_EN
      check({tag, "_conj"},  32'(bus.coeff_conj), 32'd0);
`endif
   endtask

   task automatic pulse_start(input bit inv);
      @(posedge clk); #1;
      bus.start = 1'b1;
`ifdef FFT_SEQ_INVERSE_EN
      bus.inverse = inv;
`else
      if (inv) bus.start = 1'b1;
`endif
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("first_valid", 32'(bus.bf_valid), 32'd1);
      check("first_busy",  32'(bus.busy),      32'd1);
      check("first_stage", 32'(bus.stage_idx), 32'd0);
      check("first_pass",  32'(bus.pass_idx),  32'd0);
      check("first_buf",   32'(bus.buf_sel),   32'd0);
   endtask

   task automatic run_xfer(input int dly, input int dly0, input int hold,
                           input bit rnd, input bit pokes, input bit inv);
      int n, done_before;
      bit got;
      cfg_dly = dly; cfg_dly0 = dly0; cfg_hold = hold; cfg_rnd = rnd;
      done_before = done_cnt;
      pulse_start(inv);
      n = 0; got = 1'b0;
      while (!got && n < 3000) begin
         @(posedge clk); #1;
         n++;
         bus.start = pokes && (n == 25);
         if (bus.done) begin
            got = 1'b1;
            if (pokes) bus.start = 1'b1;
         end
      end
      check("done_seen", 32'(got), 32'd1);
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("done_once", 32'(done_cnt - done_before), 32'd1);
      check("idle_busy", 32'(bus.busy), 32'd0);
      check("idle_bufsel", 32'(bus.buf_sel), 32'(LOG2N % 2));
      check("err_state", 32'(bus.err), 32'(exp_err));
   endtask

   initial begin
      int n;
      bus.start = 1'b0;
`ifdef FFT_SEQ_INVERSE_EN
      bus.inverse = 1'b0;
`endif
      #1;
      check_zero_outputs("reset");
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      run_xfer(3, 3, 0, 1'b0, 1'b0, 1'b0);
      run_xfer(3, 20, 5, 1'b0, 1'b1, 1'b1);
      run_xfer(3, 3, 0, 1'b0, 1'b0, 1'b0);

      // spurious write-back ack while idle
      spur_req++;
      repeat (3) @(posedge clk);
      #1;
      exp_err = 1'b1;
      check("spurious_err", 32'(bus.err), 32'd1);
      run_xfer(4, 4, 0, 1'b1, 1'b0, 1'b1);

      // reset in the middle of stage 3
      cfg_dly = 3; cfg_dly0 = 3; cfg_hold = 0; cfg_rnd = 1'b0;
      pulse_start(1'b1);
      n = 0;
      while (bus.stage_idx != 3 && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      check("reached_stage3", 32'(bus.stage_idx), 32'd3);
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_zero_outputs("midreset");
      exp_err = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      run_xfer(3, 3, 0, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 6; i++)
         run_xfer(3, 3, int'($urandom_range(0, 4)), 1'b1, 1'(i % 2), 1'($urandom_range(0, 1)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
